// File: rtl/sachen_pkg.sv
// Shared constants, state encoding and helpers for the
// Sachen 8259 / 74LS374N register-file restore engine.
package sachen_pkg;

    localparam logic [15:0] SEL_ADDR_DEFAULT = 16'h4100;
    localparam logic [15:0] DAT_ADDR_DEFAULT = 16'h4101;

    // Replay order: slot 0 first (243 reg-0 clobber), slot 1 is reg 2 (150 clobber)
    localparam logic [7:0][2:0] ORDER = {
        3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd1, 3'd2, 3'd0
    };

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SEL,
        DAT,
        FIN,
        RD
    } restore_state_t;

    function automatic logic [7:0] exp_readback(input logic [2:0] sel);
        return {5'b00111, ~sel};
    endfunction

endpackage

// File: rtl/sachen8259_restore.sv
// Replays a Sachen 8259 / 74LS374N register snapshot as CPU write
// cycles on the indexed port, then reads the selector back.
module sachen8259_restore
    import sachen_pkg::*;
#(
    parameter logic [15:0] SEL_ADDR = SEL_ADDR_DEFAULT,
    parameter logic [15:0] DAT_ADDR = DAT_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        start,
    input  logic        abort,
    input  logic [23:0] snap,
    input  logic [2:0]  final_sel,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_dout,
    output logic        bus_write,
    output logic        bus_read,
    input  logic [7:0]  bus_din,
    output logic        busy,
    output logic        done,
    output logic        err
);

    restore_state_t state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [23:0] snap_q, snap_d;
    logic [2:0]  fsel_q, fsel_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  dout_q, dout_d;
    logic        write_q, write_d;
    logic        read_q, read_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    function automatic logic [2:0] reg_val(
        input logic [23:0] s,
        input logic [2:0]  r
    );
        logic [2:0] v;
        v = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (r == 3'(i)) v = s[3*i +: 3];
        end
        return v;
    endfunction

    // Sequencing: advances only on ce, abort forces IDLE on any clk
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        fsel_d  = fsel_q;
        busy_d  = busy_q;
        err_d   = err_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = IDLE;
            idx_d   = 3'd0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    snap_d  = snap;
                    fsel_d  = final_sel;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ARM;
                end
                ARM: if (ce) begin
                    state_d = SEL;
                    idx_d   = 3'd0;
                end
                SEL: if (ce) state_d = DAT;
                DAT: if (ce) begin
                    if (idx_q == 3'd7) begin
                        state_d = FIN;
                    end else begin
                        state_d = SEL;
                        idx_d   = idx_q + 3'd1;
                    end
                end
                FIN: if (ce) state_d = RD;
                RD: if (ce) begin
                    err_d   = (bus_din != exp_readback(fsel_q));
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    idx_d   = 3'd0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Bus drive for the cycle being entered; IDLE and ARM park at zero
    always_comb begin
        addr_d  = 16'h0000;
        dout_d  = 8'h00;
        write_d = 1'b0;
        read_d  = 1'b0;
        case (state_d)
            SEL: begin
                addr_d  = SEL_ADDR;
                dout_d  = {5'b0, ORDER[idx_d]};
                write_d = 1'b1;
            end
            DAT: begin
                addr_d  = DAT_ADDR;
                dout_d  = {5'b0, reg_val(snap_d, ORDER[idx_d])};
                write_d = 1'b1;
            end
            FIN: begin
                addr_d  = SEL_ADDR;
                dout_d  = {5'b0, fsel_d};
                write_d = 1'b1;
            end
            RD: begin
                addr_d = SEL_ADDR;
                read_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            snap_q  <= 24'h0;
            fsel_q  <= 3'd0;
            addr_q  <= 16'h0000;
            dout_q  <= 8'h00;
            write_q <= 1'b0;
            read_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            fsel_q  <= fsel_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            write_q <= write_d;
            read_q  <= read_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus_addr  = addr_q;
    assign bus_dout  = dout_q;
    assign bus_write = write_q;
    assign bus_read  = read_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
